// File: rtl/c3lib_strap_pkg.sv
// Shared types and helpers for the strap capture block: FSM encoding,
// default parameter values and the shared counter width calculation.
package c3lib_strap_pkg;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_SETTLE_CYC = 16;
    localparam int DEF_CHK_PERIOD = 256;

    typedef enum logic [1:0] {
        SETTLE  = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2,
        CHECK   = 2'd3
    } strap_state_t;

    // One counter serves both the settle wait and the re-check interval.
    function automatic int cnt_width(input int settle_cyc, input int chk_period);
        int max_val;
        max_val = (settle_cyc > chk_period) ? settle_cyc : chk_period;
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/c3lib_bitsync.sv
// Multi-bit, multi-stage flop synchroniser for quasi-static inputs.
// Each bit is synchronised independently; no coherency between bits is implied.
module c3lib_bitsync #(
    parameter int              WIDTH   = 1,
    parameter int              STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_reg [STAGES];

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) stage_reg[gi] <= RST_VAL;
                    else        stage_reg[gi] <= d;
                end
            end else begin : g_next
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) stage_reg[gi] <= RST_VAL;
                    else        stage_reg[gi] <= stage_reg[gi-1];
                end
            end
        end
    endgenerate

    assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/c3lib_strap_capture.sv
// Settles, synchronises and captures tie-cell strap bits, then periodically
// re-checks them and flags corruption; a software override can replace the output.
module c3lib_strap_capture
    import c3lib_strap_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int CHK_PERIOD = DEF_CHK_PERIOD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] strap_in,
    input  logic             ovrd_en,
    input  logic             ovrd_wr,
    input  logic [WIDTH-1:0] ovrd_val,
    input  logic             mismatch_clr,
    output logic [WIDTH-1:0] strap_out,
    output logic             strap_vld,
    output logic             strap_mismatch
);

    localparam int CW = cnt_width(SETTLE_CYC, CHK_PERIOD);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] CHK_LAST    = CW'(CHK_PERIOD - 1);

    logic [WIDTH-1:0] strap_sync;
    logic [WIDTH-1:0] cap_reg;
    logic [WIDTH-1:0] ovrd_reg;
    logic [WIDTH-1:0] strap_out_reg;
    logic             vld_reg;
    logic             mismatch_reg;
    logic [CW-1:0]    cnt_reg;
    logic [CW-1:0]    cnt_inc;
    strap_state_t     state_reg;

    c3lib_bitsync #(
        .WIDTH   (WIDTH),
        .STAGES  (2),
        .RST_VAL ('0)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (strap_in),
        .q     (strap_sync)
    );

    assign cnt_inc = (&cnt_reg) ? cnt_reg : cnt_reg + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= SETTLE;
            cnt_reg       <= '0;
            cap_reg       <= '0;
            ovrd_reg      <= '0;
            strap_out_reg <= '0;
            vld_reg       <= 1'b0;
            mismatch_reg  <= 1'b0;
        end else begin
            if (ovrd_wr) ovrd_reg <= ovrd_val;
            // A clear is overridden below if a CHECK mismatch lands in the same cycle.
            if (mismatch_clr) mismatch_reg <= 1'b0;
            strap_out_reg <= ovrd_en ? ovrd_reg : cap_reg;

            case (state_reg)
                SETTLE: begin
                    if (cnt_reg == SETTLE_LAST) begin
                        state_reg <= CAPTURE;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_inc;
                    end
                end
                CAPTURE: begin
                    cap_reg   <= strap_sync;
                    vld_reg   <= 1'b1;
                    state_reg <= HOLD;
                    // Bypass so strap_out carries the captured word as strap_vld rises.
                    if (!ovrd_en) strap_out_reg <= strap_sync;
                end
                HOLD: begin
                    if (cnt_reg == CHK_LAST) begin
                        state_reg <= CHECK;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_inc;
                    end
                end
                CHECK: begin
                    if (strap_sync != cap_reg) mismatch_reg <= 1'b1;
                    state_reg <= HOLD;
                end
                default: state_reg <= SETTLE;
            endcase
        end
    end

    assign strap_out      = strap_out_reg;
    assign strap_vld      = vld_reg;
    assign strap_mismatch = mismatch_reg;

endmodule

// File: tb/tb_c3lib_strap_capture.sv
// Scoreboard bench: a timeline model predicts each cycle's outputs for a default
// instance and a minimum-parameter instance; predictions are queued and compared.
module tb_c3lib_strap_capture;

    logic       clk;
    logic       rst_n;
    logic [7:0] strap_in;
    logic       ovrd_en;
    logic       ovrd_wr;
    logic [7:0] ovrd_val;
    logic       mismatch_clr;
    logic [7:0] out0, out1;
    logic       vld0, vld1, mm0, mm1;

    int n_checks = 0;
    int n_errors = 0;

    c3lib_strap_capture u_dut (
        .clk(clk), .rst_n(rst_n), .strap_in(strap_in), .ovrd_en(ovrd_en),
        .ovrd_wr(ovrd_wr), .ovrd_val(ovrd_val), .mismatch_clr(mismatch_clr),
        .strap_out(out0), .strap_vld(vld0), .strap_mismatch(mm0)
    );

    c3lib_strap_capture #(.WIDTH(8), .SETTLE_CYC(1), .CHK_PERIOD(2)) u_dut_small (
        .clk(clk), .rst_n(rst_n), .strap_in(strap_in), .ovrd_en(ovrd_en),
        .ovrd_wr(ovrd_wr), .ovrd_val(ovrd_val), .mismatch_clr(mismatch_clr),
        .strap_out(out1), .strap_vld(vld1), .strap_mismatch(mm1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] out;
        logic       vld;
        logic       mm;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int         m_s[2];
    int         m_p[2];
    int         m_t[2];
    logic [7:0] m_s1[2], m_s2[2], m_cap[2], m_ovrd[2], m_out[2];
    logic       m_vld[2], m_mm[2];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Re-check edges fall at S+1 + k*(P+1), counted in edges since reset release.
    function automatic bit is_check(input int i, input int t);
        return (t > m_s[i] + 1) && (((t - (m_s[i] + 1)) % (m_p[i] + 1)) == 0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_t[i] = 0; m_s1[i] = '0; m_s2[i] = '0; m_cap[i] = '0;
            m_ovrd[i] = '0; m_out[i] = '0; m_vld[i] = 1'b0; m_mm[i] = 1'b0;
        end
    endtask

    task automatic model_edge(input int i);
        logic [7:0] s2_old, ovrd_old;
        if (!rst_n) begin
            m_t[i] = 0; m_s1[i] = '0; m_s2[i] = '0; m_cap[i] = '0;
            m_ovrd[i] = '0; m_out[i] = '0; m_vld[i] = 1'b0; m_mm[i] = 1'b0;
        end else begin
            m_t[i]++;
            s2_old   = m_s2[i];
            m_s2[i]  = m_s1[i];
            m_s1[i]  = strap_in;
            ovrd_old = m_ovrd[i];
            if (ovrd_wr) m_ovrd[i] = ovrd_val;
            if (m_t[i] == m_s[i] + 1) begin
                m_cap[i] = s2_old;
                m_vld[i] = 1'b1;
            end
            m_out[i] = ovrd_en ? ovrd_old : m_cap[i];
            if (is_check(i, m_t[i]) && (s2_old != m_cap[i])) m_mm[i] = 1'b1;
            else if (mismatch_clr)                            m_mm[i] = 1'b0;
        end
    endtask

    task automatic step();
        exp_t e0, e1;
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        q0.push_back('{out: m_out[0], vld: m_vld[0], mm: m_mm[0]});
        q1.push_back('{out: m_out[1], vld: m_vld[1], mm: m_mm[1]});
        @(negedge clk);
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        check_val("out0", {24'h0, out0}, {24'h0, e0.out});
        check_val("vld0", {31'h0, vld0}, {31'h0, e0.vld});
        check_val("mm0",  {31'h0, mm0},  {31'h0, e0.mm});
        check_val("out1", {24'h0, out1}, {24'h0, e1.out});
        check_val("vld1", {31'h0, vld1}, {31'h0, e1.vld});
        check_val("mm1",  {31'h0, mm1},  {31'h0, e1.mm});
    endtask

    task automatic step_to_check_edge();
        int n;
        n = 0;
        while (!is_check(0, m_t[0] + 1) && n < 300) begin
            step();
            n++;
        end
        check_val("check_edge_reached", {31'h0, is_check(0, m_t[0] + 1)}, 32'h1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        m_s[0] = 16; m_p[0] = 256;
        m_s[1] = 1;  m_p[1] = 2;
        model_reset();
        rst_n = 1'b0; strap_in = 8'hA5; ovrd_en = 1'b0; ovrd_wr = 1'b0;
        ovrd_val = 8'h00; mismatch_clr = 1'b0;
        repeat (3) step();

        // First release: 16 cycles of vld=0 then capture of A5.
        rst_n = 1'b1;
        repeat (16) step();
        check_val("vld_before_capture", {31'h0, vld0}, 32'h0);
        step();
        check_val("vld_at_17", {31'h0, vld0}, 32'h1);
        check_val("out_at_17", {24'h0, out0}, 32'hA5);
        repeat (5) step();

        // Corrupt one strap bit: flag must set, output must hold.
        strap_in = 8'hA4;
        n = 0;
        while (mm0 !== 1'b1 && n < 259) begin
            step();
            n++;
        end
        check_val("mm_set_in_time", {31'h0, mm0}, 32'h1);
        check_val("out_held", {24'h0, out0}, 32'hA5);

        mismatch_clr = 1'b1; step(); mismatch_clr = 1'b0;
        check_val("mm_cleared", {31'h0, mm0}, 32'h0);
        step_to_check_edge();
        step();
        check_val("mm_reset_on_check", {31'h0, mm0}, 32'h1);

        // Clear coinciding with a mismatching CHECK: set wins.
        mismatch_clr = 1'b1; step(); mismatch_clr = 1'b0;
        step_to_check_edge();
        mismatch_clr = 1'b1; step(); mismatch_clr = 1'b0;
        check_val("set_wins", {31'h0, mm0}, 32'h1);
        repeat (3) step();

        // Load an override, then reset mid-HOLD: everything including override clears.
        ovrd_val = 8'h77; ovrd_wr = 1'b1; step(); ovrd_wr = 1'b0;
        ovrd_en = 1'b1;
        repeat (2) step();
        check_val("ovrd_77", {24'h0, out0}, 32'h77);
        strap_in = 8'h0F;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_val("async_out", {24'h0, out0}, 32'h0);
        check_val("async_vld", {31'h0, vld0}, 32'h0);
        check_val("async_mm",  {31'h0, mm0},  32'h0);
        check_val("async_out_small", {24'h0, out1}, 32'h0);
        @(negedge clk);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (2) step();
        check_val("ovrd_reg_cleared", {24'h0, out0}, 32'h0);

        // Override during SETTLE shows before strap_vld.
        ovrd_val = 8'h3C; ovrd_wr = 1'b1; step(); ovrd_wr = 1'b0;
        step();
        check_val("ovrd_in_settle", {24'h0, out0}, 32'h3C);
        check_val("ovrd_vld_low", {31'h0, vld0}, 32'h0);
        while (m_t[0] < 17) step();
        check_val("vld_again", {31'h0, vld0}, 32'h1);
        check_val("ovrd_after_vld", {24'h0, out0}, 32'h3C);
        ovrd_en = 1'b0;
        step();
        check_val("captured_0f", {24'h0, out0}, 32'h0F);
        repeat (270) step();
        check_val("no_mm_static", {31'h0, mm0}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
